// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO unit: 32-cycle shift-add multiply and restoring divide, with sign fix-up.
// Results land in HI/LO 34 cycles after issue; stall holds EX while a new HI/LO user waits.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; mthi/mtlo writes are taken here
// CALC   | 32 iterations, one per edge
// SIGN   | sign correction, HI/LO write, done pulse on the next cycle
module muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mf_req,
  input  logic        mt_hi,
  input  logic        mt_lo,
  input  logic [31:0] mt_data,
  input  logic        cancel,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic        r_div;
  logic        r_sa;
  logic        r_sb;
  logic [31:0] r_b;
  logic [63:0] r_acc;
  logic [31:0] r_rem;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;

  logic        w_rs_neg;
  logic        w_rt_neg;
  logic [31:0] w_rs_abs;
  logic [31:0] w_rt_abs;
  logic [32:0] w_add;
  logic [63:0] w_mul_next;
  logic [32:0] w_shift;
  logic        w_borrow;
  logic [31:0] w_diff;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_rs_neg = op[0] & rs_data[31];
  assign w_rt_neg = op[0] & rt_data[31];
  assign w_rs_abs = w_rs_neg ? (32'd0 - rs_data) : rs_data;
  assign w_rt_abs = w_rt_neg ? (32'd0 - rt_data) : rt_data;

  // Multiply: multiplier sits in acc[31:0] and shifts out as the product shifts in.
  assign w_add      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
  assign w_mul_next = {w_add, r_acc[31:1]};

  // Divide: dividend shifts out of acc[31:0] into the 33-bit partial remainder,
  // quotient bits shift in behind it. The true difference always fits in 32 bits.
  assign w_shift    = {r_rem, r_acc[31]};
  assign w_borrow   = (w_shift < {1'b0, r_b});
  assign w_diff     = w_shift[31:0] - r_b;
  assign w_rem_next = w_borrow ? w_shift[31:0] : w_diff;
  assign w_quo_next = {r_acc[30:0], ~w_borrow};

  assign w_prod = (r_sa ^ r_sb) ? (64'd0 - r_acc) : r_acc;
  assign w_quo  = (r_sa ^ r_sb) ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  // With a zero divisor the remainder ends up as |dividend|, so this also restores rs_data.
  assign w_rem  = r_sa ? (32'd0 - r_rem) : r_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_div   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_b     <= 32'd0;
      r_acc   <= 64'd0;
      r_rem   <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !cancel) begin
            r_div   <= op[1];
            r_sa    <= w_rs_neg;
            r_sb    <= w_rt_neg;
            r_acc   <= {32'd0, (op[1] ? w_rs_abs : w_rt_abs)};
            r_b     <= op[1] ? w_rt_abs : w_rs_abs;
            r_rem   <= 32'd0;
            r_cnt   <= 6'd0;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end else begin
            if (mt_hi) r_hi <= mt_data;
            if (mt_lo) r_lo <= mt_data;
          end
        end
        S_CALC: begin
          if (cancel) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (r_div) begin
              r_rem <= w_rem_next;
              r_acc <= {r_acc[63:32], w_quo_next};
            end else begin
              r_acc <= w_mul_next;
            end
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd31) r_state <= S_SIGN;
          end
        end
        S_SIGN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (!cancel) begin
            r_done <= 1'b1;
            if (r_div) begin
              r_hi <= w_rem;
              r_lo <= (r_b == 32'd0) ? 32'hFFFF_FFFF : w_quo;
            end else begin
              r_hi <= w_prod[63:32];
              r_lo <= w_prod[31:0];
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign stall = r_busy & ~reset & (start | mf_req | mt_hi | mt_lo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table of mult/div results plus
// hand-written sequences for stall, mt writes, cancel and mid-operation reset.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, mf_req, mt_hi, mt_lo, cancel;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, mt_data;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[17];

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mf_req(mf_req),
    .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data), .cancel(cancel),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  // Called just after a rising edge with the unit idle; returns just after a rising edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string name);
    int bad_prof;
    bad_prof = 0;
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    step;
    start = 1'b0; rs_data = 32'hDEAD_BEEF; rt_data = 32'h0;
    for (int k = 1; k <= 33; k++) begin
      sample;
      if (busy !== 1'b1 || done !== 1'b0) bad_prof++;
      step;
    end
    sample;
    chk({name, " busy/done profile T+1..T+33"}, 64'(bad_prof), 64'd0);
    chk({name, " busy T+34"}, {63'd0, busy}, 64'd0);
    chk({name, " done T+34"}, {63'd0, done}, 64'd1);
    chk({name, " hi"}, {32'd0, hi}, {32'd0, ehi});
    chk({name, " lo"}, {32'd0, lo}, {32'd0, elo});
    step;
    sample;
    chk({name, " done T+35"}, {63'd0, done}, 64'd0);
    step;
  endtask

  initial begin
    int bad;
    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{2'b10, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[4]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{2'b00, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006};
    vecs[6]  = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7]  = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[8]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[10] = '{2'b11, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
    vecs[11] = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[12] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[13] = '{2'b11, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E};
    vecs[14] = '{2'b01, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[15] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0000_0006, 32'hFFFF_FFEB};
    vecs[16] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};

    reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = 32'h0; rt_data = 32'h0;
    mf_req = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0; mt_data = 32'h0; cancel = 1'b0;
    step; step;
    sample;
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset hi/lo", {hi, lo}, 64'd0);
    chk("reset stall", {63'd0, stall}, 64'd0);
    step;
    reset = 1'b0;

    // mthi/mtlo in IDLE
    mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'h55AA_55AA;
    step;
    mt_lo = 1'b0; mt_data = 32'h1234_5678;
    sample;
    chk("mthi+mtlo both", {hi, lo}, 64'h55AA_55AA_55AA_55AA);
    step;
    mt_hi = 1'b0; mt_data = 32'h0;
    sample;
    chk("mthi hi", {32'd0, hi}, 64'h1234_5678);
    chk("mthi lo kept", {32'd0, lo}, 64'h55AA_55AA);
    chk("mthi no done", {63'd0, done}, 64'd0);
    step;

    // start with mthi in IDLE drops the write; cancel at T+5
    start = 1'b1; op = 2'b00; rs_data = 32'd2; rt_data = 32'd3; mt_hi = 1'b1; mt_data = 32'hCAFE_0000;
    step;
    start = 1'b0; mt_hi = 1'b0;
    sample;
    chk("start+mthi busy T+1", {63'd0, busy}, 64'd1);
    chk("start+mthi hi kept", {32'd0, hi}, 64'h1234_5678);
    step; step; step; step;
    cancel = 1'b1;
    step;
    cancel = 1'b0;
    sample;
    chk("cancel busy T+6", {63'd0, busy}, 64'd0);
    chk("cancel hi/lo kept", {hi, lo}, 64'h1234_5678_55AA_55AA);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      step; sample;
      if (done !== 1'b0) bad++;
    end
    chk("cancel no done pulse", 64'(bad), 64'd0);
    step;

    // cancel during SIGN
    start = 1'b1; op = 2'b01; rs_data = 32'hFFFF_FFFD; rt_data = 32'd7;
    step;
    start = 1'b0;
    for (int k = 1; k < 33; k++) step;
    cancel = 1'b1;
    step;
    cancel = 1'b0;
    sample;
    chk("SIGN cancel busy", {63'd0, busy}, 64'd0);
    chk("SIGN cancel done", {63'd0, done}, 64'd0);
    chk("SIGN cancel hi/lo kept", {hi, lo}, 64'h1234_5678_55AA_55AA);
    step;

    // mf_req stall from T+10, extra start at T+3 ignored
    start = 1'b1; op = 2'b00; rs_data = 32'hFFFF_FFFF; rt_data = 32'd3;
    step;
    start = 1'b0;
    bad = 0;
    for (int k = 1; k <= 33; k++) begin
      start = (k == 3);
      op = (k == 3) ? 2'b10 : 2'b00;
      rs_data = 32'd50; rt_data = 32'd5;
      mf_req = (k >= 10);
      sample;
      if (stall !== ((k == 3) || (k >= 10))) bad++;
      step;
    end
    start = 1'b0;
    sample;
    chk("mf_req stall profile", 64'(bad), 64'd0);
    chk("mf_req stall T+34", {63'd0, stall}, 64'd0);
    chk("mf_req done T+34", {63'd0, done}, 64'd1);
    chk("mf_req hi/lo T+34", {hi, lo}, 64'h0000_0002_FFFF_FFFD);
    step;
    mf_req = 1'b0;
    step;

    // reset at T+20 during a divu, with a start also asserted
    start = 1'b1; op = 2'b10; rs_data = 32'hFFFF_FFFF; rt_data = 32'd3;
    step;
    start = 1'b0;
    for (int k = 1; k < 20; k++) step;
    reset = 1'b1; start = 1'b1;
    sample;
    chk("stall while reset", {63'd0, stall}, 64'd0);
    step;
    reset = 1'b0; start = 1'b0;
    sample;
    chk("reset mid-op busy", {63'd0, busy}, 64'd0);
    chk("reset mid-op hi/lo", {hi, lo}, 64'd0);
    chk("reset mid-op done", {63'd0, done}, 64'd0);
    step;
    run_op(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, "multu 2x3 after reset");

    for (int i = 0; i < 17; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, $sformatf("vec%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
